// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and defaults for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_I_REQ = 3'd1,
        ARB_D_REQ = 3'd2,
        ARB_I_RSP = 3'd3,
        ARB_D_RSP = 3'd4
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEF = 255;

    // A disabled watchdog (timeout 0) still keeps a one-bit counter so the ports stay used.
    function automatic int wdt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// rtl/mem_arb_wdt.sv - per-access wait-cycle watchdog for the memory arbiter
module mem_arb_wdt
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = wdt_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Saturates at the limit so a stuck run never wraps back below it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises fetch and data ports onto one variable-latency memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_ack,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              data_ack,
    output logic              stall,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              bus_err
);

    arb_state_t state, state_nxt;

    logic              d_pend;
    logic              i_pend;
    logic              in_req;
    logic              expire;
    logic              load_d;
    logic              load_i;
    logic              cap_rdata;
    logic              cap_err;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [DATA_W-1:0] rsp_data;
    logic              err_q;

    assign d_pend = mem_ren | mem_wen;
    assign i_pend = inst_ren;
    assign in_req = (state == ARB_D_REQ) || (state == ARB_I_REQ);

    mem_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clear  (~in_req),
        .run    (in_req & ~ram_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The port just acknowledged still holds its request during RSP, so only the other port is considered.
    always_comb begin
        state_nxt = state;
        load_d    = 1'b0;
        load_i    = 1'b0;
        cap_rdata = 1'b0;
        cap_err   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_pend) begin
                    load_d    = 1'b1;
                    state_nxt = ARB_D_REQ;
                end else if (i_pend) begin
                    load_i    = 1'b1;
                    state_nxt = ARB_I_REQ;
                end
            end
            ARB_D_REQ, ARB_I_REQ: begin
                if (ram_ready) begin
                    cap_rdata = 1'b1;
                end else if (expire) begin
                    cap_err = 1'b1;
                end
                if (ram_ready || expire) begin
                    state_nxt = (state == ARB_D_REQ) ? ARB_D_RSP : ARB_I_RSP;
                end
            end
            ARB_D_RSP: begin
                if (i_pend) begin
                    load_i    = 1'b1;
                    state_nxt = ARB_I_REQ;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_I_RSP: begin
                if (d_pend) begin
                    load_d    = 1'b1;
                    state_nxt = ARB_D_REQ;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // A simultaneous read and write is treated as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else if (load_d) begin
            lat_addr  <= mem_addr;
            lat_wdata <= mem_dout;
            lat_we    <= mem_wen;
        end else if (load_i) begin
            lat_addr  <= inst_addr;
            lat_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= cap_err;
            if (cap_rdata) begin
                rsp_data <= ram_rdata;
            end else if (cap_err) begin
                rsp_data <= '0;
            end
        end
    end

    assign ram_req   = in_req;
    assign ram_we    = in_req & lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

    assign inst_ack  = (state == ARB_I_RSP);
    assign data_ack  = (state == ARB_D_RSP);
    assign inst_data = rsp_data;
    assign mem_din   = rsp_data;
    assign bus_err   = err_q;

    assign stall = (i_pend & ~inst_ack) | (d_pend & ~data_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        inst_ren, mem_ren, mem_wen, ram_ready;
    logic [31:0] inst_addr, mem_addr, mem_dout, ram_rdata;
    logic [31:0] inst_data, mem_din, ram_addr, ram_wdata;
    logic        inst_ack, data_ack, stall, ram_req, ram_we, bus_err;

    logic        z_inst_ren, z_mem_ren, z_mem_wen, z_ram_ready;
    logic [31:0] z_inst_addr, z_mem_addr, z_mem_dout, z_ram_rdata;
    logic [31:0] z_inst_data, z_mem_din, z_ram_addr, z_ram_wdata;
    logic        z_inst_ack, z_data_ack, z_stall, z_ram_req, z_ram_we, z_bus_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ack(inst_ack),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .data_ack(data_ack), .stall(stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready), .bus_err(bus_err)
    );

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(0)) u_dut_nowdt (
        .clk(clk), .rst(rst),
        .inst_ren(z_inst_ren), .inst_addr(z_inst_addr), .inst_data(z_inst_data), .inst_ack(z_inst_ack),
        .mem_ren(z_mem_ren), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr), .mem_dout(z_mem_dout),
        .mem_din(z_mem_din), .data_ack(z_data_ack), .stall(z_stall),
        .ram_req(z_ram_req), .ram_we(z_ram_we), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata),
        .ram_rdata(z_ram_rdata), .ram_ready(z_ram_ready), .bus_err(z_bus_err)
    );

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int bad;

    initial begin
        rst = 1'b1;
        {inst_ren, mem_ren, mem_wen, ram_ready} = '0;
        {inst_addr, mem_addr, mem_dout, ram_rdata} = '0;
        {z_inst_ren, z_mem_ren, z_mem_wen, z_ram_ready} = '0;
        {z_inst_addr, z_mem_addr, z_mem_dout, z_ram_rdata} = '0;

        #2;
        chk_vec("rst_ram_req", ram_req, 0);
        chk_vec("rst_acks", {inst_ack, data_ack, bus_err, ram_we}, 0);
        chk_vec("rst_ram_addr", ram_addr, 0);
        chk_vec("rst_rsp", mem_din, 0);
        chk_vec("rst_stall", stall, 0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // single fetch
        inst_ren = 1; inst_addr = 32'h10; ram_ready = 1; ram_rdata = 32'h2008_0005;
        #1;
        chk_vec("f_T_stall", stall, 1);
        chk_vec("f_T_req", ram_req, 0);
        cyc();
        chk_vec("f_T1_req", ram_req, 1);
        chk_vec("f_T1_addr", ram_addr, 32'h10);
        chk_vec("f_T1_we", ram_we, 0);
        chk_vec("f_T1_ack", inst_ack, 0);
        chk_vec("f_T1_stall", stall, 1);
        cyc();
        chk_vec("f_T2_ack", inst_ack, 1);
        chk_vec("f_T2_data", inst_data, 32'h2008_0005);
        chk_vec("f_T2_stall", stall, 0);
        inst_ren = 0;
        cyc();
        chk_vec("f_T3_idle", {ram_req, inst_ack}, 0);

        // simultaneous fetch and write: data wins, fetch follows with no bubble
        inst_ren = 1; inst_addr = 32'h14;
        mem_wen = 1; mem_addr = 32'h100; mem_dout = 32'hDEAD_BEEF; ram_rdata = 32'h0;
        cyc();
        chk_vec("s_T1_req", {ram_req, ram_we}, 2'b11);
        chk_vec("s_T1_addr", ram_addr, 32'h100);
        chk_vec("s_T1_wdata", ram_wdata, 32'hDEAD_BEEF);
        cyc();
        chk_vec("s_T2_acks", {data_ack, inst_ack}, 2'b10);
        mem_wen = 0; ram_rdata = 32'hCAFE_0001;
        #1;
        chk_vec("s_T2_stall", stall, 1);
        cyc();
        chk_vec("s_T3_req", {ram_req, ram_we}, 2'b10);
        chk_vec("s_T3_addr", ram_addr, 32'h14);
        cyc();
        chk_vec("s_T4_ack", {inst_ack, data_ack}, 2'b10);
        chk_vec("s_T4_data", inst_data, 32'hCAFE_0001);
        inst_ren = 0;
        cyc();
        chk_vec("s_T5_idle", ram_req, 0);

        // data read with four wait cycles
        mem_ren = 1; mem_addr = 32'h200; ram_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk_vec($sformatf("w_T%0d_req", i), {ram_req, ram_we, data_ack}, 3'b100);
            chk_vec($sformatf("w_T%0d_addr", i), ram_addr, 32'h200);
        end
        cyc();
        chk_vec("w_T5_addr", ram_addr, 32'h200);
        ram_ready = 1; ram_rdata = 32'h1234_5678;
        cyc();
        ram_ready = 0;
        chk_vec("w_T6_ack", data_ack, 1);
        chk_vec("w_T6_data", mem_din, 32'h1234_5678);
        mem_ren = 0;
        cyc();

        // watchdog expiry with TIMEOUT=8
        mem_ren = 1; mem_addr = 32'h300; ram_rdata = 32'hFFFF_FFFF;
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (ram_req !== 1'b1 || data_ack !== 1'b0 || bus_err !== 1'b0) bad++;
        end
        chk_vec("wd_wait_cycles", bad, 0);
        cyc();
        chk_vec("wd_T10_err_ack", {bus_err, data_ack}, 2'b11);
        chk_vec("wd_T10_data", mem_din, 0);
        mem_ren = 0;
        cyc();
        chk_vec("wd_T11_idle", {bus_err, data_ack, ram_req}, 0);

        // reset in the middle of a data access
        mem_ren = 1; mem_addr = 32'h400;
        cyc();
        chk_vec("r_T1_req", ram_req, 1);
        rst = 1;
        #1;
        chk_vec("r_async_req", ram_req, 0);
        mem_ren = 0;
        cyc();
        chk_vec("r_no_ack", {data_ack, inst_ack}, 0);
        rst = 0;
        cyc();
        inst_ren = 1; inst_addr = 32'h20; ram_ready = 1; ram_rdata = 32'h0BAD_F00D;
        cyc();
        chk_vec("r_fetch_req", {ram_req, data_ack}, 2'b10);
        chk_vec("r_fetch_addr", ram_addr, 32'h20);
        cyc();
        chk_vec("r_fetch_ack", inst_ack, 1);
        chk_vec("r_fetch_data", inst_data, 32'h0BAD_F00D);
        inst_ren = 0; ram_ready = 0;
        cyc();

        // watchdog disabled: 300 wait cycles then completion
        z_mem_ren = 1; z_mem_addr = 32'h500; z_ram_ready = 0;
        bad = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (z_ram_req !== 1'b1 || z_data_ack !== 1'b0 || z_bus_err !== 1'b0) bad++;
        end
        chk_vec("nw_wait_cycles", bad, 0);
        cyc();
        chk_vec("nw_still_req", z_ram_req, 1);
        z_ram_ready = 1; z_ram_rdata = 32'h5A5A_A5A5;
        cyc();
        z_ram_ready = 0;
        chk_vec("nw_ack", {z_data_ack, z_bus_err}, 2'b10);
        chk_vec("nw_data", z_mem_din, 32'h5A5A_A5A5);
        z_mem_ren = 0;
        cyc();
        chk_vec("nw_idle", z_ram_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
